// File: rtl/fix_weighted_sum.sv
// fix_weighted_sum: multiplies N_CH unsigned fixed-point channels by
// compile-time coefficients through one shared multiplier (one channel per
// cycle), rounds/saturates the accumulated sum and hands it out over a
// valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new vector; capture data_i on in_valid_i
// MULT  | one multiply-accumulate per cycle, channel idx = 0..N_CH-1
// FINAL | round, shift out fraction, saturate, register the result
// HOLD  | result presented until out_valid_o & out_ready_i
module fix_weighted_sum #(
  parameter int                     N_CH      = 3,
  parameter int                     DATA_W    = 24,
  parameter int                     COEF_W    = 16,
  parameter int                     COEF_FRAC = 16,
  parameter logic [N_CH*COEF_W-1:0] COEFS     = {16'h1D2F, 16'h9646, 16'h4C8B},
  parameter bit                     ROUND     = 1'b1
) (
  input  logic                   clk_i_fix_wsum,
  input  logic                   rst_i_fix_wsum,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [N_CH*DATA_W-1:0] data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      result_o,
  output logic                   sat_o,
  output logic                   busy_o
);

  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  // One spare bit on top of clog2(N_CH) so the sum of N_CH full-scale
  // products plus the rounding constant can never wrap.
  localparam int ACC_W  = PROD_W + $clog2(N_CH) + 1;
  localparam logic [ACC_W-1:0] RND  = ROUND ? (ACC_W'(1) << (COEF_FRAC - 1)) : '0;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, MULT, FINAL, HOLD} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [N_CH*DATA_W-1:0] data_q;
  logic [ACC_W-1:0]       acc;
  logic [IDX_W-1:0]       idx;
  logic [DATA_W-1:0]      result_q;
  logic                   sat_q;

  logic [DATA_W-1:0]      chan [N_CH];
  logic [COEF_W-1:0]      coef [N_CH];
  logic [PROD_W-1:0]      prod;
  logic [ACC_W-1:0]       rounded;
  logic [ACC_W-1:0]       shifted;
  logic                   over;

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign chan[i] = data_q[i*DATA_W +: DATA_W];
    assign coef[i] = COEFS[i*COEF_W +: COEF_W];
  end

  assign prod    = {{COEF_W{1'b0}}, chan[idx]} * {{DATA_W{1'b0}}, coef[idx]};
  assign rounded = acc + RND;
  assign shifted = rounded >> COEF_FRAC;
  assign over    = |shifted[ACC_W-1:DATA_W];

  // State register.
  always_ff @(posedge clk_i_fix_wsum or posedge rst_i_fix_wsum) begin
    if (rst_i_fix_wsum) state <= IDLE;
    else                state <= state_next;
  end

  // Next-state logic; in_valid_i is only looked at in IDLE, out_ready_i only in HOLD.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid_i) state_next = MULT;
      MULT:    if (idx == LAST) state_next = FINAL;
      FINAL:   state_next = HOLD;
      HOLD:    if (out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture, multiply-accumulate, round/saturate into the result register.
  always_ff @(posedge clk_i_fix_wsum or posedge rst_i_fix_wsum) begin
    if (rst_i_fix_wsum) begin
      data_q   <= '0;
      acc      <= '0;
      idx      <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            data_q <= data_i;
            acc    <= '0;
            idx    <= '0;
          end
        end
        MULT: begin
          acc <= acc + {{(ACC_W-PROD_W){1'b0}}, prod};
          idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        FINAL: begin
          result_q <= over ? '1 : shifted[DATA_W-1:0];
          sat_q    <= over;
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state == IDLE);
  assign busy_o      = (state == MULT) || (state == FINAL);
  assign out_valid_o = (state == HOLD);
  assign result_o    = result_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_fix_weighted_sum.sv
// Bench for fix_weighted_sum: three instances (default luma, truncating,
// saturating coefficients) share one stimulus stream; expected results are
// queued at acceptance and checked when the outputs are handed over.
module tb_fix_weighted_sum;

  localparam logic [47:0] DEF_C = 48'h1D2F_9646_4C8B;
  localparam logic [47:0] SAT_C = 48'hFFFF_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             out_ready;
  logic [71:0]      data;
  logic [2:0]       in_ready;
  logic [2:0]       out_valid;
  logic [2:0]       sat;
  logic [2:0]       busy;
  logic [2:0][23:0] result;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [2:0][23:0] res;
    logic [2:0]       sat;
    int               acc_cyc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fix_weighted_sum u_def (
    .clk_i_fix_wsum(clk), .rst_i_fix_wsum(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready[0]), .data_i(data),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
    .result_o(result[0]), .sat_o(sat[0]), .busy_o(busy[0]));

  fix_weighted_sum #(.ROUND(1'b0)) u_trunc (
    .clk_i_fix_wsum(clk), .rst_i_fix_wsum(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready[1]), .data_i(data),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
    .result_o(result[1]), .sat_o(sat[1]), .busy_o(busy[1]));

  fix_weighted_sum #(.COEF_FRAC(15), .COEFS(SAT_C)) u_sat (
    .clk_i_fix_wsum(clk), .rst_i_fix_wsum(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready[2]), .data_i(data),
    .out_valid_o(out_valid[2]), .out_ready_i(out_ready),
    .result_o(result[2]), .sat_o(sat[2]), .busy_o(busy[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: exact 64-bit sum of products, optional half-LSB, shift, clip.
  function automatic logic [24:0] model(input logic [71:0] d, input logic [47:0] c,
                                        input int frac, input bit rnd);
    longint unsigned acc;
    longint unsigned t;
    acc = 0;
    for (int i = 0; i < 3; i++)
      acc += longint'(d[i*24 +: 24]) * longint'(c[i*16 +: 16]);
    if (rnd) acc += 64'd1 << (frac - 1);
    t = acc >> frac;
    if (t > 64'hFF_FFFF) return {1'b1, 24'hFF_FFFF};
    return {1'b0, t[23:0]};
  endfunction

  function automatic logic [71:0] rand72();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  task automatic send(input logic [71:0] d, output int acc_cyc);
    int          n;
    exp_t        e;
    logic [24:0] m;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    data     = d;
    while (in_ready[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(in_ready[0]), 64'd1);
    m = model(d, DEF_C, 16, 1'b1); e.res[0] = m[23:0]; e.sat[0] = m[24];
    m = model(d, DEF_C, 16, 1'b0); e.res[1] = m[23:0]; e.sat[1] = m[24];
    m = model(d, SAT_C, 15, 1'b1); e.res[2] = m[23:0]; e.sat[2] = m[24];
    e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    acc_cyc = e.acc_cyc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    data     = rand72();
    chk("busy_after_accept", 64'(busy[0]), 64'd1);
    chk("in_ready_in_mult", 64'(in_ready[0]), 64'd0);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int dummy;
    int a0;
    int a1;
    int n;
    logic [71:0] vec_a;
    logic [71:0] vec_b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data      = '0;

    // Output monitor: latency, hold stability, one-cycle valid, scoreboard pop.
    fork
      begin : monitor
        logic        prev_ov;
        logic        prev_xfer;
        logic [23:0] prev_res;
        logic        prev_sat;
        exp_t        e;
        prev_ov   = 1'b0;
        prev_xfer = 1'b0;
        prev_res  = '0;
        prev_sat  = 1'b0;
        forever begin
          @(negedge clk);
          #1;
          if (rst) begin
            prev_ov   = 1'b0;
            prev_xfer = 1'b0;
          end else begin
            if (prev_xfer) chk("valid_drops_after_xfer", 64'(out_valid[0]), 64'd0);
            if (out_valid[0]) begin
              chk("instances_agree", 64'(out_valid), 64'h7);
              if (!prev_ov) begin
                chk("output_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0)
                  chk("latency", 64'(cyc - exp_q[0].acc_cyc), 64'd4);
              end else if (!prev_xfer) begin
                chk("hold_result_stable", 64'(result[0]), 64'(prev_res));
                chk("hold_sat_stable", 64'(sat[0]), 64'(prev_sat));
              end
              if (out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                  chk($sformatf("result[%0d]", k), 64'(result[k]), 64'(e.res[k]));
                  chk($sformatf("sat[%0d]", k), 64'(sat[k]), 64'(e.sat[k]));
                end
              end
            end
            prev_xfer = out_valid[0] & out_ready;
            prev_ov   = out_valid[0];
            prev_res  = result[0];
            prev_sat  = sat[0];
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_out_valid[%0d]", k), 64'(out_valid[k]), 64'd0);
      chk($sformatf("rst_result[%0d]", k), 64'(result[k]), 64'd0);
      chk($sformatf("rst_sat[%0d]", k), 64'(sat[k]), 64'd0);
      chk($sformatf("rst_busy[%0d]", k), 64'(busy[k]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("rst_in_ready[%0d]", k), 64'(in_ready[k]), 64'd1);

    // Directed vectors, downstream always ready ({B,G,R}, R = channel 0)
    out_ready = 1'b1;
    send({24'd100, 24'd100, 24'd100}, dummy);
    send({24'd0, 24'd0, 24'd255}, dummy);
    send({3{24'hFF_FFFF}}, dummy);
    send({24'd0, 24'd1, 24'd0}, dummy);

    // Back-to-back throughput: one vector per N_CH+3 cycles
    send(rand72(), a0);
    send(rand72(), a1);
    chk("throughput", 64'(a1 - a0), 64'd6);
    wait_empty();

    // Back-pressure: new vector offered while a result is held
    vec_a = {24'd300, 24'd200, 24'd100};
    vec_b = {3{24'hFF_FFFF}};
    out_ready = 1'b0;
    send(vec_a, dummy);
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 64'(out_valid[0]), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      data     = vec_b;
      chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
      chk("bp_busy", 64'(busy[0]), 64'd0);
    end
    out_ready = 1'b1;
    send(vec_b, dummy);
    wait_empty();

    // Reset in the middle of MULT discards the transaction
    send({24'd100, 24'd100, 24'd100}, dummy);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_out_valid[%0d]", k), 64'(out_valid[k]), 64'd0);
      chk($sformatf("midrst_result[%0d]", k), 64'(result[k]), 64'd0);
      chk($sformatf("midrst_sat[%0d]", k), 64'(sat[k]), 64'd0);
      chk($sformatf("midrst_busy[%0d]", k), 64'(busy[k]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("midrst_in_ready[%0d]", k), 64'(in_ready[k]), 64'd1);
    repeat (10) @(negedge clk);
    chk("no_stale_result", 64'(out_valid), 64'd0);

    // Random vectors
    for (int i = 0; i < 4; i++) send(rand72(), dummy);
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fix_weighted_sum.md
Name: fix_weighted_sum

Overview:
- Parametrised successor to the fixed RGB constant multiplier.
- Multiplies N_CH unsigned fixed-point channels by per-channel unsigned fixed-point coefficients and accumulates the products. A single shared multiplier is used, processing one channel per cycle.
- Rounds and saturates the sum, then returns it over a valid/ready handshake.
- Sits after the float-to-fixed stage in the pixel path. Default configuration is RGB-to-luma (0.299/0.587/0.114).

Parameters:
- N_CH, 3: number of input channels (1..16).
- DATA_W, 24: width of each channel and of the result.
- COEF_W, 16: coefficient width, unsigned.
- COEF_FRAC, 16: fractional bits of the coefficients (1..COEF_W).
- COEFS, {16'h1D2F,16'h9646,16'h4C8B}: packed N_CH*COEF_W vector. Channel 0 is in the LSBs. Defaults are 0.299, 0.587, 0.114 in Q0.16 and sum to exactly 65536.
- ROUND, 1: 1 = round half up, 0 = truncate.

Ports:
- clk_i_fix_wsum  in  1  clock, rising edge.
- rst_i_fix_wsum  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  input vector valid.
- in_ready_o  out  1  block can accept a vector.
- data_i  in  N_CH*DATA_W  channel inputs, channel 0 in the LSBs.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- result_o  out  DATA_W  weighted sum.
- sat_o  out  1  result was clipped; qualified by out_valid_o.
- busy_o  out  1  computation in progress.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; accumulator, channel index and captured data are cleared.
  - result_o=0, sat_o=0, out_valid_o=0, busy_o=0, in_ready_o=1 once released.
  - Reset mid-computation or mid-hold discards the transaction; no out_valid_o pulse follows.
- State machine: IDLE -> MULT -> FINAL -> HOLD -> IDLE.
- IDLE:
  - in_ready_o=1.
  - When in_valid_i=1 at a clock edge, capture all of data_i into an internal register. Clear the accumulator and set the index to 0, then go to MULT.
  - data_i is don't-care after acceptance.
- MULT:
  - busy_o=1, in_ready_o=0.
  - Each cycle: acc += data[idx]*coef[idx], with an unsigned product of DATA_W+COEF_W bits.
  - acc width is DATA_W+COEF_W+clog2(N_CH)+1, so it never overflows.
  - After idx=N_CH-1 go to FINAL. Exactly N_CH cycles are spent in MULT.
- FINAL (1 cycle), with busy_o=1:
  - t = (acc + (ROUND ? 2^(COEF_FRAC-1) : 0)) >> COEF_FRAC.
  - If t > 2^DATA_W-1, then result_o = all ones and sat_o=1; otherwise result_o = t[DATA_W-1:0] and sat_o=0.
  - Register the result, set out_valid_o=1, go to HOLD.
- Latency: with acceptance at edge E0, out_valid_o is first high after edge E0+N_CH+1.
- HOLD:
  - busy_o=0, in_ready_o=0.
  - result_o, sat_o and out_valid_o stay stable until out_valid_o & out_ready_i at an edge.
  - At that edge out_valid_o drops and the state returns to IDLE.
  - result_o/sat_o keep their last value after the transfer.
- Throughput: one vector per N_CH+3 cycles when out_ready_i is tied high. There is no overlap of accept and output.
- in_valid_i during MULT/FINAL/HOLD is ignored; the upstream must hold its data until in_ready_o=1.
- out_ready_i outside HOLD has no effect.
- Coefficients are compile-time constants. Zero coefficients are legal and contribute 0.

Test Plan:
- Reset: assert rst_i_fix_wsum mid-MULT with R=G=B=100 -> out_valid_o=0, result_o=0, in_ready_o=1 after release; no stale result ever appears.
- Defaults, out_ready_i=1, R=G=B=100 -> result_o=100, sat_o=0, out_valid_o high exactly after edge E0+4, for one cycle.
- Defaults, R=255, G=0, B=0 -> result_o=76 (acc=4996725). All channels 0xFFFFFF -> result_o=0xFFFFFF, sat_o=0.
- Rounding, R=0, G=1, B=0: ROUND=1 -> result_o=1; ROUND=0 -> result_o=0.
- Saturation: COEFS all 16'hFFFF, COEF_FRAC=15, all channels 0xFFFFFF -> result_o=0xFFFFFF, sat_o=1.
- Back-pressure: hold out_ready_i=0 for 5 cycles after out_valid_o and pulse in_valid_i with new data -> result_o stable, in_ready_o=0, new data not taken; after out_ready_i=1 the new vector is accepted and produces its own correct result.
